// File: rtl/max_pkg.sv
// Shared constants and the per-stage record for the max-tree pipeline.
// stage_t widths follow W_DEF/N_DEF; retune these when changing the lane geometry.
package max_pkg;

    localparam int W_DEF  = 8;
    localparam int N_DEF  = 4;
    localparam int IW_DEF = $clog2(N_DEF);

    typedef struct packed {
        logic              valid;
        logic              mode;
        logic              last;
        logic [W_DEF-1:0]  max;
        logic [IW_DEF-1:0] idx;
    } stage_t;

endpackage

// File: rtl/max2_sel.sv
// Two-input unsigned compare-select; combinational, no backpressure.
// Operand a must carry the lower lane index so that ties resolve to it.
module max2_sel #(
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic [W-1:0]  i_a_max,
    input  logic [IW-1:0] i_a_idx,
    input  logic [W-1:0]  i_b_max,
    input  logic [IW-1:0] i_b_idx,
    output logic [W-1:0]  o_max,
    output logic [IW-1:0] o_idx
);

    logic w_b_wins;

    assign w_b_wins = i_b_max > i_a_max;
    assign o_max    = w_b_wins ? i_b_max : i_a_max;
    assign o_idx    = w_b_wins ? i_b_idx : i_a_idx;

endmodule

// File: rtl/max_tree_pipe.sv
// Lane max/argmax: log2(N) registered tree levels + one accumulator stage (log2(N)+1 cycles).
// Whole pipeline freezes while a result is held un-accepted; in_ready = out_ready | ~out_valid.
module max_tree_pipe
    import max_pkg::*;
#(
    parameter  int W  = W_DEF,
    parameter  int N  = N_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_last,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_max,
    output logic [IW-1:0]  out_idx
);

    localparam int L = IW;

    logic          w_en;
    // Heap numbering: node 1 is the root, nodes N..2N-1 are the input lanes.
    logic [W-1:0]  w_nd_max  [1:2*N-1];
    logic [IW-1:0] w_nd_idx  [1:2*N-1];
    logic [W-1:0]  w_sel_max [1:N-1];
    logic [IW-1:0] w_sel_idx [1:N-1];
    logic [W-1:0]  r_nd_max  [1:N-1];
    logic [IW-1:0] r_nd_idx  [1:N-1];

    logic [L:1]    r_vld;
    logic [L:1]    r_mode;
    logic [L:1]    r_last;

    stage_t        w_root;
    logic          r_act;
    logic [W-1:0]  r_acc_max;
    logic [IW-1:0] r_acc_idx;
    logic          r_out_vld;
    logic [W-1:0]  r_out_max;
    logic [IW-1:0] r_out_idx;

    logic          w_take;
    logic [W-1:0]  w_cand_max;
    logic [IW-1:0] w_cand_idx;
    logic          w_act_nxt;
    logic          w_out_vld_nxt;
    logic [W-1:0]  w_out_max_nxt;
    logic [IW-1:0] w_out_idx_nxt;
    logic [W-1:0]  w_acc_max_nxt;
    logic [IW-1:0] w_acc_idx_nxt;

    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    for (genvar k = 0; k < N; k++) begin : g_leaf
        assign w_nd_max[N+k] = in_data[k*W +: W];
        assign w_nd_idx[N+k] = IW'(k);
    end

    for (genvar j = 1; j < N; j++) begin : g_node
        max2_sel #(.W(W), .IW(IW)) u_sel (
            .i_a_max (w_nd_max[2*j]),
            .i_a_idx (w_nd_idx[2*j]),
            .i_b_max (w_nd_max[2*j+1]),
            .i_b_idx (w_nd_idx[2*j+1]),
            .o_max   (w_sel_max[j]),
            .o_idx   (w_sel_idx[j])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_nd_max[j] <= '0;
                r_nd_idx[j] <= '0;
            end else if (w_en) begin
                r_nd_max[j] <= w_sel_max[j];
                r_nd_idx[j] <= w_sel_idx[j];
            end
        end

        assign w_nd_max[j] = r_nd_max[j];
        assign w_nd_idx[j] = r_nd_idx[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_mode <= '0;
            r_last <= '0;
        end else if (w_en) begin
            r_vld[1]  <= in_valid;
            r_mode[1] <= mode;
            r_last[1] <= in_last;
            for (int s = 2; s <= L; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_mode[s] <= r_mode[s-1];
                r_last[s] <= r_last[s-1];
            end
        end
    end

    always_comb begin
        w_root.valid = r_vld[L];
        w_root.mode  = r_mode[L];
        w_root.last  = r_last[L];
        w_root.max   = w_nd_max[1];
        w_root.idx   = w_nd_idx[1];
    end

    // Earlier beat keeps the frame max on ties: replace only when strictly greater.
    always_comb begin
        w_take        = ~r_act | (w_root.max > r_acc_max);
        w_cand_max    = w_take ? w_root.max : r_acc_max;
        w_cand_idx    = w_take ? w_root.idx : r_acc_idx;
        w_act_nxt     = r_act;
        w_out_vld_nxt = 1'b0;
        w_out_max_nxt = r_out_max;
        w_out_idx_nxt = r_out_idx;
        w_acc_max_nxt = r_acc_max;
        w_acc_idx_nxt = r_acc_idx;
        if (w_root.valid) begin
            if (!w_root.mode) begin
                w_act_nxt     = 1'b0;
                w_out_vld_nxt = 1'b1;
                w_out_max_nxt = w_root.max;
                w_out_idx_nxt = w_root.idx;
            end else if (w_root.last) begin
                w_act_nxt     = 1'b0;
                w_out_vld_nxt = 1'b1;
                w_out_max_nxt = w_cand_max;
                w_out_idx_nxt = w_cand_idx;
            end else begin
                w_act_nxt     = 1'b1;
                w_acc_max_nxt = w_cand_max;
                w_acc_idx_nxt = w_cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act     <= 1'b0;
            r_acc_max <= '0;
            r_acc_idx <= '0;
            r_out_vld <= 1'b0;
            r_out_max <= '0;
            r_out_idx <= '0;
        end else if (w_en) begin
            r_act     <= w_act_nxt;
            r_acc_max <= w_acc_max_nxt;
            r_acc_idx <= w_acc_idx_nxt;
            r_out_vld <= w_out_vld_nxt;
            r_out_max <= w_out_max_nxt;
            r_out_idx <= w_out_idx_nxt;
        end
    end

    assign out_valid = r_out_vld;
    assign out_max   = r_out_max;
    assign out_idx   = r_out_idx;

endmodule

// File: doc/max_tree_pipe.md
MAX_TREE_PIPE -- requirements
Module: max_tree_pipe

Interface
REQ-001 SHALL have parameter W, 8, unsigned lane width in bits (W >= 1).
REQ-002 SHALL have parameter N, 4, lane count (power of two, 2..64).
REQ-003 SHALL have parameter IW, $clog2(N), index width (derived, not overridden).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port in_data  input  N*W  lane k at bits [k*W +: W].
REQ-009 SHALL have port in_last  input  1  final beat of frame (mode 1 only).
REQ-010 SHALL have port mode  input  1  0 = per-beat max, 1 = frame running max; sampled with beat.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_max  output  W  maximum value.
REQ-014 SHALL have port out_idx  output  IW  lane index of maximum.

Function
REQ-015 SHALL accept a beat when in_valid & in_ready; SHALL compute en = out_ready | ~out_valid and drive in_ready = en.
REQ-016 SHALL implement a compare tree of log2(N) registered levels followed by one registered accumulator stage; all stages advance only when en = 1.
REQ-017 SHALL carry valid, mode and last alongside data in every stage; bubbles propagate as valid = 0.
REQ-018 SHALL compare unsigned; on equal values SHALL select the lower lane index.
REQ-019 Mode 0: SHALL present each beat's max/idx at out_valid exactly log2(N)+1 accepted-advance cycles after acceptance (3 cycles for N=4 with out_ready held high).
REQ-020 Mode 1: accumulator SHALL load the tree result on the first frame beat, afterwards load only if tree max is strictly greater (earlier beat wins ties).
REQ-021 Mode 1: out_valid SHALL assert only for a beat carrying in_last, with the frame max/idx including that beat; accumulator SHALL then clear.
REQ-022 Single-beat frame (mode 1, in_last on first beat) SHALL output that beat's result.
REQ-023 A mode-0 beat arriving at the accumulator while a mode-1 frame is open SHALL abort the frame (accumulator cleared) and output its own result.
REQ-024 While out_valid & ~out_ready, out_max/out_idx SHALL hold stable and no stage SHALL advance.
REQ-025 in_last on mode-0 beats SHALL be ignored.

Reset
REQ-026 On rst_n low, all stage valids, out_valid and accumulator-active flag SHALL clear to 0 asynchronously; out_max, out_idx SHALL reset to 0.
REQ-027 Reset mid-frame SHALL discard partial frame and in-flight beats; first beat after release starts a new frame.
REQ-028 in_ready SHALL be 1 during and immediately after reset (out_valid = 0).

Structure
REQ-029 Shared package max_pkg SHALL hold default W/N constants and the stage struct type (valid, mode, last, max, idx).
REQ-030 One sub-module max2_sel (combinational two-input compare-select, tie to lower index) SHALL be instantiated N-1 times across tree levels.

Verification
REQ-031 Mode 0, N=4, in_data lanes {0x10,0x80,0x7F,0x05}, out_ready=1 -> 3 cycles later out_max=0x80, out_idx=1.
REQ-032 Ties: lanes {0x40,0x40,0x40,0x40} -> out_max=0x40, out_idx=0; {0x00,0x33,0x00,0x33} -> idx=1.
REQ-033 Mode 1 frame of 3 beats with maxima 0x20@idx2, 0x90@idx3, 0x90@idx0 (last) -> single output 0x90, idx=3; no out_valid for first two beats.
REQ-034 Backpressure: out_ready=0 for 5 cycles with stream of 6 beats -> in_ready drops once out_valid set, output held stable, all 6 results delivered in order, none lost or duplicated.
REQ-035 Reset asserted after 2 beats of a mode-1 frame, then new 1-beat frame {0x01,0x02,0x03,0x04} last -> output 0x04, idx=3 only.
REQ-036 Mode-0 beat {0xFF,0,0,0} injected mid mode-1 frame -> output 0xFF idx 0; following mode-1 beats start new frame.
